// File: rtl/conv1d_mac_ctrl_pkg.sv
// Shared types and constants for the conv1d MAC sequencer and its address generator.
package conv1d_mac_ctrl_pkg;

   localparam int DEF_WIDTH_DATA = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   function automatic int psum_width(input int width_data);
      return 2 * width_data;
   endfunction

endpackage

// File: rtl/conv1d_addr_gen.sv
// Tap/output/base counters for the conv1d sequencer; presents the read addresses of the
// tap currently being issued and flags the first tap, last tap and last output.
module conv1d_addr_gen
   import conv1d_mac_ctrl_pkg::*;
#(
   parameter int KLEN_W  = 5,
   parameter int OLEN_W  = 10,
   parameter int FADDR_W = 10,
   parameter int WADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init,
   input  logic               step_tap,
   input  logic               next_out,
   input  logic [KLEN_W-1:0]  cfg_klen,
   input  logic [OLEN_W-1:0]  cfg_olen,
   input  logic [FADDR_W-1:0] cfg_stride,
   output logic [FADDR_W-1:0] feat_addr,
   output logic [WADDR_W-1:0] wgt_addr,
   output logic               first_tap,
   output logic               last_tap,
   output logic               last_out
);

   logic [KLEN_W-1:0]  k;
   logic [OLEN_W-1:0]  o;
   logic [FADDR_W-1:0] base;
   logic [KLEN_W-1:0]  klen_q;
   logic [OLEN_W-1:0]  olen_q;
   logic [FADDR_W-1:0] stride_q;

   // feat_addr is kept as its own register (base+k) so no adder sits on the address path
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k         <= '0;
         o         <= '0;
         base      <= '0;
         feat_addr <= '0;
         klen_q    <= '0;
         olen_q    <= '0;
         stride_q  <= '0;
      end else if (init) begin
         k         <= '0;
         o         <= '0;
         base      <= '0;
         feat_addr <= '0;
         klen_q    <= cfg_klen;
         olen_q    <= cfg_olen;
         stride_q  <= cfg_stride;
      end else if (step_tap) begin
         k         <= k + KLEN_W'(1);
         feat_addr <= feat_addr + FADDR_W'(1);
      end else if (next_out) begin
         k         <= '0;
         o         <= o + OLEN_W'(1);
         base      <= base + stride_q;
         feat_addr <= base + stride_q;
      end
   end

   assign wgt_addr  = WADDR_W'(k);
   assign first_tap = (k == '0);
   assign last_tap  = (k == klen_q - KLEN_W'(1));
   assign last_out  = (o == olen_q - OLEN_W'(1));

endmodule

// File: rtl/conv1d_mac_ctrl.sv
// Conv1d MAC sequencer: walks K taps per output, accumulates via an external MAC and
// streams one sum per output. Optional CONV1D_RELU_EN clamps negative results to zero.
module conv1d_mac_ctrl
   import conv1d_mac_ctrl_pkg::*;
#(
   parameter int WIDTH_DATA = DEF_WIDTH_DATA,
   parameter int KLEN_W     = 5,
   parameter int OLEN_W     = 10,
   parameter int FADDR_W    = 10,
   parameter int WADDR_W    = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [KLEN_W-1:0]       cfg_klen,
   input  logic [OLEN_W-1:0]       cfg_olen,
   input  logic [FADDR_W-1:0]      cfg_stride,
   output logic                    busy,
   output logic                    done,
   output logic                    feat_rd_en,
   output logic                    wgt_rd_en,
   output logic [FADDR_W-1:0]      feat_addr,
   output logic [WADDR_W-1:0]      wgt_addr,
   input  logic [WIDTH_DATA-1:0]   feat_data,
   input  logic [WIDTH_DATA-1:0]   wgt_data,
   output logic [WIDTH_DATA-1:0]   mac_weight,
   output logic [WIDTH_DATA-1:0]   mac_feature,
   output logic [2*WIDTH_DATA-1:0] mac_psum_in,
   input  logic [2*WIDTH_DATA-1:0] mac_psum_out,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [2*WIDTH_DATA-1:0] out_data,
   output logic                    out_last
);

   localparam int PSUM_W = psum_width(WIDTH_DATA);

   state_t             state;
   logic               rd_en;
   logic               data_vld;
   logic               data_first;
   logic [PSUM_W-1:0]  acc;
   logic [PSUM_W-1:0]  result;
   logic               cfg_ok;
   logic               init;
   logic               step_tap;
   logic               next_out;
   logic               first_tap;
   logic               last_tap;
   logic               last_out;

   conv1d_addr_gen #(
      .KLEN_W  (KLEN_W),
      .OLEN_W  (OLEN_W),
      .FADDR_W (FADDR_W),
      .WADDR_W (WADDR_W)
   ) u_addr_gen (
      .clk        (clk),
      .rst        (rst),
      .init       (init),
      .step_tap   (step_tap),
      .next_out   (next_out),
      .cfg_klen   (cfg_klen),
      .cfg_olen   (cfg_olen),
      .cfg_stride (cfg_stride),
      .feat_addr  (feat_addr),
      .wgt_addr   (wgt_addr),
      .first_tap  (first_tap),
      .last_tap   (last_tap),
      .last_out   (last_out)
   );

   always_comb begin
      cfg_ok   = (cfg_klen != '0) && (cfg_olen != '0);
      init     = (state == IDLE) && start && cfg_ok;
      step_tap = (state == RUN) && !last_tap;
      next_out = (state == OUT) && out_ready && !last_out;
   end

   assign feat_rd_en  = rd_en;
   assign wgt_rd_en   = rd_en;
   assign mac_weight  = wgt_data;
   assign mac_feature = feat_data;
   assign mac_psum_in = data_first ? '0 : acc;

`ifdef CONV1D_RELU_EN
   always_comb result = mac_psum_out[PSUM_W-1] ? '0 : mac_psum_out;
`else
   always_comb result = mac_psum_out;
`endif

   // data_vld/data_first track the tap whose read data arrives this cycle (one behind issue)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         rd_en      <= 1'b0;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_last   <= 1'b0;
         acc        <= '0;
         data_vld   <= 1'b0;
         data_first <= 1'b0;
      end else begin
         done       <= 1'b0;
         data_vld   <= rd_en;
         data_first <= rd_en && first_tap;
         if (data_vld)
            acc <= mac_psum_out;
         case (state)
            IDLE: begin
               if (start) begin
                  if (cfg_ok) begin
                     state <= RUN;
                     busy  <= 1'b1;
                     rd_en <= 1'b1;
                     acc   <= '0;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (last_tap) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
               end
            end
            DRAIN: begin
               state     <= OUT;
               out_valid <= 1'b1;
               out_data  <= result;
               out_last  <= last_out;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  if (last_out) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     rd_en <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Scoreboard bench for conv1d_mac_ctrl: SRAM and MAC models around the DUT, expected sums
// computed directly from the convolution definition.
module tb_conv1d_mac_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  cfg_klen;
   logic [9:0]  cfg_olen;
   logic [9:0]  cfg_stride;
   logic        busy, done, feat_rd_en, wgt_rd_en;
   logic [9:0]  feat_addr;
   logic [4:0]  wgt_addr;
   logic [7:0]  feat_data, wgt_data, mac_weight, mac_feature;
   logic [15:0] mac_psum_in, mac_psum_out, out_data;
   logic        out_valid, out_ready, out_last;

   conv1d_mac_ctrl #(
      .WIDTH_DATA (8),
      .KLEN_W     (5),
      .OLEN_W     (10),
      .FADDR_W    (10),
      .WADDR_W    (5)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .cfg_klen     (cfg_klen),
      .cfg_olen     (cfg_olen),
      .cfg_stride   (cfg_stride),
      .busy         (busy),
      .done         (done),
      .feat_rd_en   (feat_rd_en),
      .wgt_rd_en    (wgt_rd_en),
      .feat_addr    (feat_addr),
      .wgt_addr     (wgt_addr),
      .feat_data    (feat_data),
      .wgt_data     (wgt_data),
      .mac_weight   (mac_weight),
      .mac_feature  (mac_feature),
      .mac_psum_in  (mac_psum_in),
      .mac_psum_out (mac_psum_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_last     (out_last)
   );

   always #5 clk = ~clk;

   logic [7:0] feat_mem [1024];
   logic [7:0] wgt_mem  [32];

   always @(posedge clk) begin
      if (feat_rd_en) feat_data <= feat_mem[feat_addr];
      if (wgt_rd_en)  wgt_data  <= wgt_mem[wgt_addr];
   end

   logic signed [15:0] prod;
   assign prod         = $signed(mac_weight) * $signed(mac_feature);
   assign mac_psum_out = mac_psum_in + prod;

   typedef struct packed {
      logic [15:0] data;
      logic        last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   stall_seen = 0;
   int   stall_cnt = 0;
   int   ready_mode = 0;
   logic prev_hold = 1'b0;
   logic [15:0] prev_data;
   logic        prev_last;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: out_ready = 1'b1;
         1: out_ready = 1'($urandom_range(0, 1));
         default: begin
            if (out_valid && stall_cnt < 7) begin
               out_ready = 1'b0;
               stall_cnt++;
            end else begin
               out_ready = 1'b1;
               if (!out_valid) stall_cnt = 0;
            end
         end
      endcase
   end

   // Monitor: pops the scoreboard on every handshake and polices the hold rules
   always @(negedge clk) begin
      if (rst) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
         end
         if (out_valid) begin
            chk("no_read_in_out", feat_rd_en | wgt_rd_en, 0);
            if (!out_ready) stall_seen++;
            if (out_ready) begin
               chk("sb_nonempty", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  exp_t e;
                  e = sb.pop_front();
                  chk("out_data", out_data, e.data);
                  chk("out_last", out_last, e.last);
               end
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         prev_last = out_last;
         if (done) done_cnt++;
      end
   end

   task automatic push_expected(input int k, input int n, input int st);
      for (int o = 0; o < n; o++) begin
         int   sum;
         exp_t e;
         sum = 0;
         for (int j = 0; j < k; j++)
            sum += int'($signed(feat_mem[(o * st + j) % 1024])) * int'($signed(wgt_mem[j]));
         e.data = sum[15:0];
`ifdef CONV1D_RELU_EN
         if (sum[15]) e.data = 16'h0000;
`endif
         e.last = (o == n - 1);
         sb.push_back(e);
      end
   endtask

   task automatic run_job(input int k, input int n, input int st, input bit timed, input bit poke);
      int t, first_v, done_t, d0;
      push_expected(k, n, st);
      d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; cfg_klen = 5'(k); cfg_olen = 10'(n); cfg_stride = 10'(st);
      @(negedge clk);
      start = 1'b0; cfg_klen = 5'($urandom); cfg_olen = 10'($urandom); cfg_stride = 10'($urandom);
      t = 1; first_v = 0; done_t = 0;
      chk("first_read", feat_rd_en & wgt_rd_en, 1);
      while (t < 3000) begin
         if (out_valid && first_v == 0) first_v = t;
         if (done) begin
            done_t = t;
            break;
         end
         if (poke && t == 3) begin
            start = 1'b1; cfg_klen = 5'($urandom_range(1, 31)); cfg_olen = 10'($urandom_range(1, 4));
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         t++;
      end
      start = 1'b0;
      chk("job_timeout", done_t != 0, 1);
      chk("busy_at_done", busy, 0);
      if (timed) begin
         chk("first_valid_lat", first_v, k + 2);
         chk("done_lat", done_t, n * (k + 2) + 1);
      end
      @(negedge clk);
      #1;
      chk("done_pulse_once", done_cnt - d0, 1);
      chk("done_one_cycle", done, 0);
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic zero_job(input int k, input int n);
      @(negedge clk);
      start = 1'b1; cfg_klen = 5'(k); cfg_olen = 10'(n); cfg_stride = 10'd5;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_rd", feat_rd_en | wgt_rd_en, 0);
      @(negedge clk);
      chk("zero_done_clr", done, 0);
      chk("zero_idle", busy | feat_rd_en, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rd"}, {feat_rd_en, wgt_rd_en}, 0);
      chk({tag, "_faddr"}, feat_addr, 0);
      chk({tag, "_waddr"}, wgt_addr, 0);
      chk({tag, "_psum_in"}, mac_psum_in, 0);
      chk({tag, "_valid"}, out_valid, 0);
      chk({tag, "_data"}, out_data, 0);
      chk({tag, "_last"}, out_last, 0);
   endtask

   task automatic fill_random();
      for (int i = 0; i < 1024; i++) feat_mem[i] = 8'($urandom);
      for (int i = 0; i < 32; i++)   wgt_mem[i]  = 8'($urandom);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; out_ready = 1'b1;
      cfg_klen = '0; cfg_olen = '0; cfg_stride = '0;
      fill_random();
      #12;
      chk_reset("por");
      @(negedge clk);
      rst = 1'b0;

      feat_mem[0] = 8'd1; feat_mem[1] = 8'd2; feat_mem[2] = 8'd3; feat_mem[3] = 8'd4;
      wgt_mem[0] = 8'd1; wgt_mem[1] = 8'd1; wgt_mem[2] = 8'd1;
      run_job(3, 2, 1, 1, 0);

      feat_mem[0] = 8'h80; wgt_mem[0] = 8'h80;
      run_job(1, 1, 0, 1, 0);

      feat_mem[0] = 8'hFD; wgt_mem[0] = 8'd5;
      run_job(1, 1, 0, 1, 0);

      fill_random();
      ready_mode = 2; stall_seen = 0;
      run_job(3, 2, 1, 0, 0);
      chk("stall_cycles", stall_seen, 14);
      ready_mode = 0;

      zero_job(0, 3);
      zero_job(4, 0);

      fill_random();
      run_job(5, 2, 7, 1, 1);
      run_job(4, 3, 1022, 1, 0);
      run_job(31, 1, 0, 1, 0);

      for (int i = 0; i < 8; i++) begin
         fill_random();
         ready_mode = i % 2;
         run_job($urandom_range(1, 31), $urandom_range(1, 4), $urandom_range(0, 1023), ready_mode == 0, 0);
      end
      ready_mode = 0;

      @(negedge clk);
      start = 1'b1; cfg_klen = 5'd10; cfg_olen = 10'd2; cfg_stride = 10'd3;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_reading", feat_rd_en, 1);
      #2 rst = 1'b1;
      #1 chk_reset("mid");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", {busy, done, out_valid, feat_rd_en}, 0);
      end
      fill_random();
      run_job(6, 2, 2, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv1d_mac_ctrl.md
# conv1d_mac_ctrl

Sequencer for the conv1d multiply-accumulate datapath. It walks a 1-D kernel over a feature buffer and drives one combinational MAC per tap through its weight/feature/psum_in/psum_out ports. It keeps the running partial sum in a register and streams one finished sum per output position over a valid/ready port. It sits between the feature/weight SRAMs and the downstream output FIFO.

## Interface
Parameters:
- WIDTH_DATA, `WIDTH_DATA (8): operand width; psum width is 2*WIDTH_DATA
- KLEN_W, 5: width of kernel-length config (K max 31)
- OLEN_W, 10: width of output-count config
- FADDR_W, 10: feature buffer address width
- WADDR_W, 5: weight buffer address width (≥ KLEN_W)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle job request; sampled only in IDLE
- cfg_klen  in  KLEN_W  taps per output K; captured at start
- cfg_olen  in  OLEN_W  outputs per job N; captured at start
- cfg_stride  in  FADDR_W  feature address step between outputs; captured at start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the job ends
- feat_rd_en / wgt_rd_en  out  1  synchronous buffer read strobes (data valid the next cycle)
- feat_addr  out  FADDR_W;  wgt_addr  out  WADDR_W
- feat_data / wgt_data  in  WIDTH_DATA  buffer read data
- mac_weight / mac_feature  out  WIDTH_DATA  MAC operands (= wgt_data / feat_data)
- mac_psum_in  out  2*WIDTH_DATA  0 on first tap of an output, else accumulator
- mac_psum_out  in  2*WIDTH_DATA  MAC result
- out_valid  out  1;  out_ready  in  1;  out_data  out  2*WIDTH_DATA;  out_last  out  1 (marks output N-1)

## Operation
- States: IDLE, RUN, DRAIN, OUT.
- IDLE → RUN on start when K≠0 and N≠0. Config is latched, tap k=0, output o=0, base=0.
- start with K=0 or N=0: no reads; done pulses the next cycle; the block stays in IDLE.
- RUN issues one tap per cycle with feat_rd_en=wgt_rd_en=1, feat_addr=base+k, wgt_addr=k. After tap K-1 is issued, RUN → DRAIN.
- Data for the tap issued in cycle t arrives in t+1. In that cycle acc ← mac_psum_out, and mac_psum_in=0 if that tap was k=0.
- DRAIN accumulates the last tap, then moves to OUT.
- OUT holds out_valid=1 and out_data=acc stable until out_ready. On handshake:
  - if o=N-1: pulse done and go to IDLE;
  - otherwise: o+1, base+=stride, k=0, go to RUN.
- Arithmetic is signed two's complement, wrapping mod 2^(2*WIDTH_DATA). Addresses wrap mod 2^FADDR_W. base is incremental; no multiplier.
- start during busy is ignored. The config inputs are don't-care outside the start cycle.

## Timing
- Reset values: busy=0, done=0, feat_rd_en=wgt_rd_en=0, addresses=0, mac_psum_in=0, out_valid=0, out_data=0, out_last=0, acc=0, state IDLE.
- Reset asserted mid-job aborts immediately. No done pulse, no further outputs, and config is not retained.
- Start accepted at edge E: first reads in cycle E+1; out_valid first high in cycle E+K+2.
- Per-output cost is K+2 cycles when out_ready is held high. A stall in OUT adds cycles 1:1.
- done is asserted in the cycle after the final handshake. busy falls in that same cycle.
- out_valid never drops without a handshake. out_data does not change while out_valid=1.

## Configuration
- CONV1D_RELU_EN defined: out_data = 0 when acc is negative (MSB=1), else acc. The internal accumulator is unaffected.
- Undefined: out_data = acc verbatim.

## Structure
- The shared package / define.v holds WIDTH_DATA, the state encoding localparams (IDLE=0, RUN=1, DRAIN=2, OUT=3) and the psum width macro.
- One natural sub-module: conv1d_addr_gen, holding the k/o/base counters and the last-tap/last-output flags. The FSM, accumulator and output port stay in the top module.

## Test plan
- K=3, N=2, stride=1; features 1,2,3,4; weights 1,1,1: out_data = 6 then 9, out_last on the second, done once, first out_valid at E+5.
- K=1, N=1, feature=-128, weight=-128 (8-bit): out_data=16384, one-cycle output with out_ready high.
- Negative sum: feature -3, weight 5, K=1. With CONV1D_RELU_EN: 0. Without: 0xFFF1.
- out_ready held low 7 cycles in OUT: out_valid and out_data stable throughout, no new reads, correct value on release.
- K=0 start → done next cycle, no rd_en. A start during busy → ignored, job count unchanged.
- rst pulsed mid-RUN: all outputs return to reset values asynchronously. A subsequent start runs cleanly with the accumulator cleared.
